// File: rtl/adder_stim_pkg.sv
// Shared constants, FSM state type and LFSR step for the adder stimulus/checker.
// The optional CE_STALL_EN build adds a second LFSR that randomly stalls ce.
package adder_stim_pkg;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;  // x^32+x^22+x^2+x+1, Galois form
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;
   localparam int          CNT_W        = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ({1'b0, s[31:1]} ^ LFSR_POLY) : {1'b0, s[31:1]};
   endfunction

endpackage

// File: rtl/adder_stim_checker_lfsr32.sv
// 32-bit Galois LFSR. val_o is the value in use this cycle: SEED while load_i is high,
// so a reload and the first use of the seed happen in the same cycle.
module lfsr32 import adder_stim_pkg::*; #(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        ck,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   output logic [31:0] val_o
);

   logic [31:0] lfsr_q, lfsr_d;

   assign val_o = load_i ? SEED : lfsr_q;

   always_comb begin
      lfsr_d = val_o;
      if (step_i) lfsr_d = lfsr_next(val_o);
   end

   always_ff @(posedge ck) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/adder_stim_checker.sv
// Drives LFSR operands into a two-stage registered adder and checks every sum.
// CE_STALL_EN: ce in RUN/DRAIN follows a free-running second LFSR instead of staying high.
module adder_stim_checker import adder_stim_pkg::*; #(
   parameter int          N    = 32,
   parameter int          LEN  = 256,
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             start,
   output logic             ce,
   output logic [N-1:0]     da,
   output logic [N-1:0]     db,
   input  logic [N-1:0]     qo,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] vec_cnt
);

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

   state_e           state_q;
   logic             ce_q, done_q, pass_q;
   logic [N-1:0]     da_q, db_q;
   logic             v1_q, v2_q, cmp_q;
   logic [N-1:0]     exp1_q, exp2_q;
   logic [CNT_W-1:0] err_q, err_d, vec_q;

   logic             accept, issue, finish, mis, ce_run;
   logic [31:0]      lv, lv_swap;
   logic [N-1:0]     sum;

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign issue  = accept || (state_q == RUN && ce_q && vec_q != LEN_C);
   // Last compare is the one whose strobe fires after v1 has emptied.
   assign finish = (state_q == DRAIN) && cmp_q && !v1_q;

   lfsr32 #(.SEED(SEED)) u_lfsr (
      .ck(ck), .rst_n(rst_n), .load_i(accept), .step_i(issue), .val_o(lv)
   );

`ifdef CE_STALL_EN
   logic [31:0] aux;
   lfsr32 #(.SEED(~SEED)) u_aux (
      .ck(ck), .rst_n(rst_n), .load_i(1'b0), .step_i(1'b1), .val_o(aux)
   );
   assign ce_run = aux[0];
`else
   assign ce_run = 1'b1;
`endif

   assign lv_swap = {lv[15:0], lv[31:16]};
   assign sum     = da_q + db_q;
   assign mis     = cmp_q && (qo != exp2_q);
   assign err_d   = (mis && err_q != '1) ? err_q + CNT_W'(1) : err_q;

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ce_q    <= 1'b0;
         da_q    <= '0;
         db_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         exp1_q  <= '0;
         exp2_q  <= '0;
         cmp_q   <= 1'b0;
         err_q   <= '0;
         vec_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         // Expected-sum pipeline mirrors the adder: moves only on ce edges.
         if (ce_q) begin
            v1_q   <= (state_q == RUN);
            exp1_q <= sum;
            v2_q   <= v1_q;
            exp2_q <= exp1_q;
         end
         cmp_q <= ce_q & v1_q;
         err_q <= err_d;
         if (issue) begin
            da_q  <= lv[N-1:0];
            db_q  <= lv_swap[N-1:0];
            vec_q <= accept ? CNT_W'(1) : vec_q + CNT_W'(1);
         end
         case (state_q)
            IDLE, DONE: if (accept) begin
               state_q <= RUN;
               ce_q    <= ce_run;
               err_q   <= '0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
               v1_q    <= 1'b0;
               v2_q    <= 1'b0;
               cmp_q   <= 1'b0;
            end
            RUN: begin
               ce_q <= ce_run;
               if (ce_q && vec_q == LEN_C) state_q <= DRAIN;
            end
            DRAIN: begin
               if (finish) begin
                  state_q <= DONE;
                  ce_q    <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                  v1_q    <= 1'b0;
                  v2_q    <= 1'b0;
               end else begin
                  ce_q <= ce_run;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ce      = ce_q;
   assign da      = da_q;
   assign db      = db_q;
   assign busy    = (state_q == RUN) || (state_q == DRAIN);
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;
   assign vec_cnt = vec_q;

endmodule
